freq_mult_tracker: RTL and testbench

//  Parametrised frequency multiplier with a measurement controller.
//  - Measures the period of an asynchronous input square wave in reference-clock cycles, averaged over 2**AVG_LOG2 periods.
//  - Loads a half-period divisor and generates out_freq at 2**MULT_LOG2 times the input frequency.
//  - Optional continuous re-tracking. Sits between the input conditioning and the clock-out pin logic.

---
 rtl/freq_mult_tracker.sv | 158 +++++++++++++++
 tb/tb_freq_mult_tracker.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_mult_tracker.sv
// freq_mult_tracker: measures the period of an asynchronous square wave in
// reference-clock cycles (averaged over 2**AVG_LOG2 periods) and drives
// out_freq at 2**MULT_LOG2 times the measured input frequency.
module freq_mult_tracker #(
    parameter int CNT_W        = 16,
    parameter int MULT_LOG2    = 3,
    parameter int AVG_LOG2     = 2,
    parameter int SYNC_STAGES  = 2,
    parameter int AUTO_RETRACK = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_freq,
    input  logic             adjust,
    output logic             out_freq,
    output logic             valid,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] half_period
);

    // Total divide from the averaged count to one output half-period.
    localparam int SHIFT  = AVG_LOG2 + MULT_LOG2 + 1;
    localparam int EDGE_W = AVG_LOG2 + 1;
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'((1 << AVG_LOG2) - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE, INIT, WAIT_EDGE, MEASURE, LOAD, ERR
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_d;
    logic                   rise;

    logic [CNT_W-1:0]  meas_cnt;
    logic [EDGE_W-1:0] edge_cnt;
    logic [CNT_W-1:0]  gen_cnt;
    logic [CNT_W-1:0]  half_raw;
    logic [CNT_W-1:0]  half_new;

    // Synchronise in_freq and keep one extra delayed copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            sync_d <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_freq};
            sync_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~sync_d;

    // Divisor for the next load; a too-fast input would give 0, so clamp to 1.
    assign half_raw = meas_cnt >> SHIFT;
    assign half_new = (half_raw == '0) ? CNT_ONE : half_raw;

    assign busy = (state == INIT) || (state == WAIT_EDGE) ||
                  (state == MEASURE) || (state == LOAD);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; adjust during a measurement restarts from INIT.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (adjust) state_nxt = INIT;
            INIT:      if (!adjust) state_nxt = WAIT_EDGE;
            WAIT_EDGE: begin
                if (adjust)    state_nxt = INIT;
                else if (rise) state_nxt = MEASURE;
            end
            MEASURE: begin
                if (adjust)                              state_nxt = INIT;
                else if (meas_cnt == CNT_MAX)            state_nxt = ERR;
                else if (rise && (edge_cnt == EDGE_LAST)) state_nxt = LOAD;
            end
            LOAD:      state_nxt = (AUTO_RETRACK != 0) ? WAIT_EDGE : IDLE;
            ERR:       state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Measurement counters, result registers and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meas_cnt    <= '0;
            edge_cnt    <= '0;
            err         <= 1'b0;
            valid       <= 1'b0;
            period_cnt  <= '0;
            half_period <= '0;
        end else begin
            case (state)
                INIT: begin
                    meas_cnt <= '0;
                    edge_cnt <= '0;
                    err      <= 1'b0;
                    valid    <= 1'b0;
                end
                WAIT_EDGE: begin
                    if (adjust) begin
                        valid <= 1'b0;
                    end else if (rise) begin
                        meas_cnt <= '0;
                        edge_cnt <= '0;
                    end
                end
                MEASURE: begin
                    if (adjust) begin
                        valid <= 1'b0;
                    end else if (meas_cnt != CNT_MAX) begin
                        meas_cnt <= meas_cnt + 1'b1;
                        if (rise) edge_cnt <= edge_cnt + 1'b1;
                    end
                end
                LOAD: begin
                    period_cnt  <= meas_cnt;
                    half_period <= half_new;
                    valid       <= 1'b1;
                end
                ERR: begin
                    err   <= 1'b1;
                    valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Output generator: half-period down-counter; LOAD restarts it without a toggle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gen_cnt  <= '0;
            out_freq <= 1'b0;
        end else if (state == LOAD) begin
            gen_cnt <= half_new;
        end else if (!valid || (state == INIT) || (state == ERR)) begin
            gen_cnt  <= '0;
            out_freq <= 1'b0;
        end else if (gen_cnt <= CNT_ONE) begin
            gen_cnt  <= half_period;
            out_freq <= ~out_freq;
        end else begin
            gen_cnt <= gen_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_freq_mult_tracker.sv
// Bench for freq_mult_tracker: dut0 (single-shot) is driven from a vector
// table with a load scoreboard; dut1 (auto-retrack) covers re-tracking and
// asynchronous reset.
module tb_freq_mult_tracker;

    localparam int CNT_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0 = 1'b1, rst1 = 1'b1;
    logic in0 = 1'b0, in1 = 1'b0;
    logic adj0 = 1'b0, adj1 = 1'b0;
    logic out0, valid0, busy0, err0;
    logic out1, valid1, busy1, err1;
    logic [CNT_W-1:0] pc0, hp0, pc1, hp1;

    freq_mult_tracker #(.CNT_W(16), .MULT_LOG2(3), .AVG_LOG2(2), .SYNC_STAGES(2), .AUTO_RETRACK(0)) dut0 (
        .clk(clk), .rst(rst0), .in_freq(in0), .adjust(adj0),
        .out_freq(out0), .valid(valid0), .busy(busy0), .err(err0),
        .period_cnt(pc0), .half_period(hp0));

    freq_mult_tracker #(.CNT_W(16), .MULT_LOG2(3), .AVG_LOG2(2), .SYNC_STAGES(2), .AUTO_RETRACK(1)) dut1 (
        .clk(clk), .rst(rst1), .in_freq(in1), .adjust(adj1),
        .out_freq(out1), .valid(valid1), .busy(busy1), .err(err1),
        .period_cnt(pc1), .half_period(hp1));

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Square-wave sources, changed on the falling clock edge.
    int   in_half0 = 32, in_half1 = 32;
    logic gen_en0 = 1'b1, gen_en1 = 1'b1;
    always begin
        repeat (in_half0) @(negedge clk);
        if (gen_en0) in0 = ~in0;
    end
    always begin
        repeat (in_half1) @(negedge clk);
        if (gen_en1) in1 = ~in1;
    end

    // Scoreboard for dut0: one entry per expected completed measurement.
    typedef struct { int pc; int hp; } exp_t;
    exp_t sb[$];
    exp_t e_mon;
    logic busy0_q = 1'b0;

    always @(negedge clk) begin
        busy0_q <= busy0;
        if (busy0_q && !busy0 && valid0) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL sb_unexpected_load: period_cnt=%0d with nothing expected", pc0);
            end else begin
                e_mon = sb.pop_front();
                chk("sb_period_cnt", int'(pc0), e_mon.pc);
                chk("sb_half_period", int'(hp0), e_mon.hp);
            end
        end
    end

    // dut1 watcher: valid must never drop and no output level may be short.
    logic watch1 = 1'b0, drop1 = 1'b0, seen1 = 1'b0, prev1 = 1'b0;
    int   run1 = 0, min1 = 1000;
    always @(negedge clk) begin
        prev1 <= out1;
        if (!watch1) begin
            run1  <= 0;
            seen1 <= 1'b0;
        end else begin
            if (!valid1) drop1 <= 1'b1;
            if (out1 != prev1) begin
                if (seen1 && run1 < min1) min1 <= run1;
                seen1 <= 1'b1;
                run1  <= 1;
            end else begin
                run1 <= run1 + 1;
            end
        end
    end

    task automatic pulse_adj0(input int n);
        @(negedge clk); adj0 = 1'b1;
        repeat (n) @(negedge clk);
        adj0 = 1'b0;
    endtask

    task automatic pulse_adj1(input int n);
        @(negedge clk); adj1 = 1'b1;
        repeat (n) @(negedge clk);
        adj1 = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (sb.size() != 0 && g < 3000) begin @(negedge clk); g++; end
        chk("sb_drain", sb.size(), 0);
    endtask

    // Skip to an out0 edge, then measure four full levels in clk cycles.
    task automatic check_levels(input int exp);
        logic lvl;
        int   cnt;
        int   g = 0;
        @(negedge clk);
        lvl = out0;
        while (out0 == lvl && g < 1000) begin @(negedge clk); g++; end
        for (int k = 0; k < 4; k++) begin
            lvl = out0;
            cnt = 0;
            while (out0 == lvl && cnt < 1000) begin @(negedge clk); cnt++; end
            chk("out_level_len", cnt, exp);
        end
    endtask

    task automatic wait_valid1(input string name);
        int g = 0;
        while (!valid1 && g < 3000) begin @(negedge clk); g++; end
        chk(name, int'(valid1), 1);
    endtask

    typedef struct { int half_in; int exp_pc; int exp_hp; } vec_t;
    vec_t tbl[5];

    initial begin
        int g;
        tbl[0] = '{32, 256, 4};   // period 64: basic multiply
        tbl[1] = '{4, 32, 1};     // period 8: divisor clamped from 0
        tbl[2] = '{64, 512, 8};   // period 128
        tbl[3] = '{20, 160, 2};   // period 40
        tbl[4] = '{50, 400, 6};   // period 100: remainder truncated

        // Reset state
        #1;
        chk("rst_out_freq", int'(out0), 0);
        chk("rst_valid", int'(valid0), 0);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_err", int'(err0), 0);
        chk("rst_period_cnt", int'(pc0), 0);
        chk("rst_half_period", int'(hp0), 0);
        repeat (3) @(negedge clk);
        rst0 = 1'b0;
        rst1 = 1'b0;

        // Table-driven measurements on dut0
        for (int i = 0; i < 5; i++) begin
            in_half0 = tbl[i].half_in;
            repeat (6 * tbl[i].half_in) @(negedge clk);
            sb.push_back('{tbl[i].exp_pc, tbl[i].exp_hp});
            pulse_adj0(3);
            drain();
            @(negedge clk);
            chk("idle_busy", int'(busy0), 0);
            chk("idle_valid", int'(valid0), 1);
            chk("idle_err", int'(err0), 0);
            check_levels(tbl[i].exp_hp);
        end

        // Abort mid-measure after two rises, then a fresh 128-clk measurement
        in_half0 = 64;
        repeat (400) @(negedge clk);
        pulse_adj0(3);
        repeat (320) @(negedge clk);
        adj0 = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_busy", int'(busy0), 1);
        chk("abort_valid", int'(valid0), 0);
        chk("abort_out", int'(out0), 0);
        repeat (2) @(negedge clk);
        sb.push_back('{512, 8});
        adj0 = 1'b0;
        drain();
        check_levels(8);

        // Auto-retrack on dut1: period 64 -> 128 without dropping valid
        in_half1 = 32;
        repeat (200) @(negedge clk);
        pulse_adj1(3);
        wait_valid1("retrack_first_valid");
        @(negedge clk);
        chk("retrack_hp_first", int'(hp1), 4);
        chk("retrack_pc_first", int'(pc1), 256);
        watch1 = 1'b1;
        repeat (300) @(negedge clk);
        in_half1 = 64;
        g = 0;
        while (hp1 != 16'd8 && g < 3000) begin @(negedge clk); g++; end
        chk("retrack_hp_new", int'(hp1), 8);
        chk("retrack_pc_new", int'(pc1), 512);
        repeat (100) @(negedge clk);
        watch1 = 1'b0;
        chk("retrack_valid_held", int'(drop1), 0);
        chk("retrack_min_level_ge4", int'(min1 >= 4), 1);
        chk("retrack_busy", int'(busy1), 1);

        // Asynchronous reset mid-measure with the output running
        repeat (150) @(negedge clk);
        chk("prerst_valid", int'(valid1), 1);
        #2;
        rst1 = 1'b1;
        #1;
        chk("arst_out_freq", int'(out1), 0);
        chk("arst_valid", int'(valid1), 0);
        chk("arst_busy", int'(busy1), 0);
        chk("arst_err", int'(err1), 0);
        chk("arst_period_cnt", int'(pc1), 0);
        chk("arst_half_period", int'(hp1), 0);
        @(negedge clk);
        rst1 = 1'b0;
        repeat (3) @(negedge clk);
        pulse_adj1(3);
        wait_valid1("rerun_valid");
        @(negedge clk);
        chk("rerun_pc", int'(pc1), 512);
        chk("rerun_hp", int'(hp1), 8);

        // Overflow on dut0: one rise, then the input stays low
        gen_en0 = 1'b0;
        @(negedge clk); in0 = 1'b0;
        pulse_adj0(3);
        repeat (5) @(negedge clk);
        in0 = 1'b1;
        repeat (10) @(negedge clk);
        in0 = 1'b0;
        g = 10;
        while (!err0 && g < 70000) begin @(negedge clk); g++; end
        chk("ovf_err", int'(err0), 1);
        chk("ovf_latency_in_range", int'(g >= 65530 && g <= 65550), 1);
        repeat (2) @(negedge clk);
        chk("ovf_valid", int'(valid0), 0);
        chk("ovf_out", int'(out0), 0);
        chk("ovf_busy", int'(busy0), 0);
        chk("ovf_err_sticky", int'(err0), 1);
        @(negedge clk); adj0 = 1'b1;
        repeat (2) @(negedge clk);
        chk("ovf_err_cleared", int'(err0), 0);
        chk("ovf_init_busy", int'(busy0), 1);
        adj0 = 1'b0;
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
